// File: rtl/rv32im_dmem_pipe.sv
// RV32IM data memory with a single outstanding load and fixed read latency.
// Stores commit on the accept edge; loads capture the addressed word at accept
// and present the extended result READ_LAT cycles later, held until taken.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned accesses are flagged,
// stores suppressed and loads return 0). Without it, misaligned accesses are
// silently aligned down and o_dm_misalign is tied low.
module rv32im_dmem_pipe #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned READ_LAT    = 2,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_dm_req_valid,
   output logic                  o_dm_req_ready,
   input  logic                  i_dm_we,
   input  logic [ADDR_WIDTH-1:0] i_dm_addr,
   input  logic [31:0]           i_dm_data_in,
   input  logic [2:0]            i_dm_func3,
   output logic                  o_dm_rsp_valid,
   input  logic                  i_dm_rsp_ready,
   output logic [31:0]           o_dm_data_out,
   output logic                  o_dm_misalign
);

   localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
   localparam logic [1:0]  CntInit = 2'(READ_LAT - 1);

   typedef enum logic [1:0] {StIdle, StLwait, StResp} state_e;

   state_e           state_q;
   logic [1:0]       cnt_q;
   logic             rsp_valid_q;
   logic [31:0]      dout_q;

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [31:0]      ld_word_q;
   logic [1:0]       ld_off_q;
   logic             ld_byte_q;
   logic             ld_half_q;
   logic             ld_sign_q;
   logic             ld_mis_q;

   logic             accept;
   logic             wr_en;
   logic             ld_acc;
   logic             is_byte;
   logic             is_half;
   logic             misalign;
   logic [1:0]       off;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [IdxW-1:0]  idx;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_ext;

   // Address bits above the array size are deliberately ignored (address wrap).
   logic unused_addr;
   assign unused_addr = ^i_dm_addr[ADDR_WIDTH-1:IdxW+2];

   assign o_dm_req_ready = (state_q == StIdle);
   assign accept         = i_dm_req_valid & o_dm_req_ready;
   assign idx            = i_dm_addr[IdxW+1:2];

   // Decode access size; unused funct3 encodings fall through to a full word.
   always_comb begin
      is_byte = 1'b0;
      is_half = 1'b0;
      case (i_dm_func3)
         3'b000:  is_byte = 1'b1;
         3'b001:  is_half = 1'b1;
         3'b100:  is_byte = ~i_dm_we;
         3'b101:  is_half = ~i_dm_we;
         default: ;
      endcase
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic is_word;
   logic misalign_q;

   assign is_word  = ~is_byte & ~is_half;
   assign misalign = (is_half & i_dm_addr[0]) | (is_word & (i_dm_addr[1:0] != 2'b00));

   // One-cycle flag following any misaligned accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= accept & misalign;
      end
   end

   assign o_dm_misalign = misalign_q;
`else
   assign misalign      = 1'b0;
   assign o_dm_misalign = 1'b0;
`endif

   assign wr_en  = accept & i_dm_we & ~misalign;
   assign ld_acc = accept & ~i_dm_we;

   // Lane offset with offending low bits dropped (aligned down).
   always_comb begin
      off   = 2'b00;
      be    = 4'b1111;
      wdata = i_dm_data_in;
      if (is_byte) begin
         off   = i_dm_addr[1:0];
         be    = 4'b0001 << off;
         wdata = {4{i_dm_data_in[7:0]}};
      end else if (is_half) begin
         off   = {i_dm_addr[1], 1'b0};
         be    = i_dm_addr[1] ? 4'b1100 : 4'b0011;
         wdata = {2{i_dm_data_in[15:0]}};
      end
   end

   // Storage array and load capture; memory is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
      if (ld_acc) begin
         ld_word_q <= mem_q[idx];
         ld_off_q  <= off;
         ld_byte_q <= is_byte;
         ld_half_q <= is_half;
         ld_sign_q <= ~i_dm_func3[2];
         ld_mis_q  <= misalign;
      end
   end

   // Lane select and sign/zero extension of the captured word.
   always_comb begin
      byte_sel = ld_word_q[{ld_off_q, 3'b000} +: 8];
      half_sel = ld_off_q[1] ? ld_word_q[31:16] : ld_word_q[15:0];
      load_ext = ld_word_q;
      if (ld_mis_q) begin
         load_ext = 32'h0;
      end else if (ld_byte_q) begin
         load_ext = ld_sign_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end else if (ld_half_q) begin
         load_ext = ld_sign_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
   end

   // Request/response FSM with registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= 2'd0;
         rsp_valid_q <= 1'b0;
         dout_q      <= 32'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (ld_acc) begin
                  state_q <= StLwait;
                  cnt_q   <= CntInit;
               end
            end
            StLwait: begin
               if (cnt_q == 2'd0) begin
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
                  dout_q      <= load_ext;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            StResp: begin
               if (i_dm_rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
                  dout_q      <= 32'h0;
               end
            end
            default: begin
               state_q     <= StIdle;
               rsp_valid_q <= 1'b0;
               dout_q      <= 32'h0;
            end
         endcase
      end
   end

   assign o_dm_rsp_valid = rsp_valid_q;
   assign o_dm_data_out  = dout_q;

endmodule

// File: tb/tb_rv32im_dmem_pipe.sv
// Self-checking bench for rv32im_dmem_pipe: directed vectors plus a short
// randomised run against a word-array reference model, with a response
// scoreboard fed at issue time and drained by a negedge monitor.
module tb_rv32im_dmem_pipe;

   localparam int unsigned DEPTH    = 64;
   localparam int unsigned LAT      = 3;
   localparam int unsigned AW       = 32;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit          TRAP     = 1'b1;
`else
   localparam bit          TRAP     = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          i_dm_req_valid;
   logic          o_dm_req_ready;
   logic          i_dm_we;
   logic [AW-1:0] i_dm_addr;
   logic [31:0]   i_dm_data_in;
   logic [2:0]    i_dm_func3;
   logic          o_dm_rsp_valid;
   logic          i_dm_rsp_ready;
   logic [31:0]   o_dm_data_out;
   logic          o_dm_misalign;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            acc_cyc  = 0;
   logic          valid_prev = 1'b0;
   logic [31:0]   exp_q [$];
   logic [31:0]   mdl [DEPTH];

   rv32im_dmem_pipe #(
      .DEPTH_WORDS (DEPTH),
      .READ_LAT    (LAT),
      .ADDR_WIDTH  (AW)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_dm_req_valid (i_dm_req_valid),
      .o_dm_req_ready (o_dm_req_ready),
      .i_dm_we        (i_dm_we),
      .i_dm_addr      (i_dm_addr),
      .i_dm_data_in   (i_dm_data_in),
      .i_dm_func3     (i_dm_func3),
      .o_dm_rsp_valid (o_dm_rsp_valid),
      .i_dm_rsp_ready (i_dm_rsp_ready),
      .o_dm_data_out  (o_dm_data_out),
      .o_dm_misalign  (o_dm_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // 0 = byte, 1 = half, 2 = word
   function automatic int size_of(input logic we, input logic [2:0] f3);
      case (f3)
         3'b000:  return 0;
         3'b001:  return 1;
         3'b100:  return we ? 2 : 0;
         3'b101:  return we ? 2 : 1;
         default: return 2;
      endcase
   endfunction

   function automatic bit is_mis(input int sz, input logic [31:0] a);
      if (sz == 1) return a[0];
      if (sz == 2) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      int          sz;
      logic [31:0] w;
      sz = size_of(1'b1, f3);
      if (TRAP && is_mis(sz, a)) return;
      w = mdl[widx(a)];
      if (sz == 0) w[8*a[1:0] +: 8] = d[7:0];
      else if (sz == 1) begin
         if (a[1]) w[31:16] = d[15:0];
         else      w[15:0]  = d[15:0];
      end else w = d;
      mdl[widx(a)] = w;
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
      int          sz;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      sz = size_of(1'b0, f3);
      if (TRAP && is_mis(sz, a)) return 32'h0;
      w = mdl[widx(a)];
      b = w[8*a[1:0] +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      if (sz == 0) return (f3 == 3'b000) ? {{24{b[7]}}, b} : {24'h0, b};
      if (sz == 1) return (f3 == 3'b001) ? {{16{h[15]}}, h} : {16'h0, h};
      return w;
   endfunction

   // Drive one request; waits (bounded) for req_ready, checks the misalign flag.
   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input bit push, input logic [31:0] exp);
      int unsigned guard;
      bit          mis;
      guard = 0;
      @(negedge clk);
      while (!o_dm_req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!o_dm_req_ready) begin
         check_eq("req_ready_timeout", 32'(o_dm_req_ready), 32'd1);
         return;
      end
      mis            = TRAP && is_mis(size_of(we, f3), a);
      i_dm_req_valid = 1'b1;
      i_dm_we        = we;
      i_dm_addr      = a;
      i_dm_data_in   = d;
      i_dm_func3     = f3;
      if (push) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (!we) acc_cyc = cyc;
      i_dm_req_valid = 1'b0;
      check_eq("misalign_flag", 32'(o_dm_misalign), 32'(mis));
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      model_store(a, d, f3);
      issue(1'b1, a, d, f3, 1'b0, 32'h0);
   endtask

   task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
      issue(1'b0, a, 32'h0, f3, 1'b1, exp);
   endtask

   task automatic drain();
      int unsigned guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check_eq("scoreboard_drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Response monitor: latency, idle-zero data and scoreboard pops.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!o_dm_rsp_valid) check_eq("dout_zero_when_idle", o_dm_data_out, 32'h0);
         if (o_dm_rsp_valid && !valid_prev)
            check_eq("rsp_latency", 32'(cyc - acc_cyc), 32'(LAT));
         if (o_dm_rsp_valid && i_dm_rsp_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_rsp", 32'(o_dm_rsp_valid), 32'd0);
            else check_eq("load_data", o_dm_data_out, exp_q.pop_front());
         end
      end
      valid_prev = o_dm_rsp_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned guard;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f3;
      logic        we;

      rst_n          = 1'b0;
      i_dm_req_valid = 1'b0;
      i_dm_we        = 1'b0;
      i_dm_addr      = '0;
      i_dm_data_in   = '0;
      i_dm_func3     = '0;
      i_dm_rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("reset_req_ready", 32'(o_dm_req_ready), 32'd1);
      check_eq("reset_rsp_valid", 32'(o_dm_rsp_valid), 32'd0);
      check_eq("reset_data_out", o_dm_data_out, 32'h0);
      check_eq("reset_misalign", 32'(o_dm_misalign), 32'd0);

      // Basic word round trip (load immediately after store sees new data).
      st(32'd0, 32'hDEADBEEF, 3'b010);
      ld(32'd0, 3'b010, 32'hDEADBEEF);
      drain();

      // Sign/zero extension.
      st(32'd12, 32'hFFFFFFFB, 3'b010);
      ld(32'd12, 3'b000, 32'hFFFFFFFB);
      ld(32'd12, 3'b100, 32'h000000FB);
      ld(32'd12, 3'b001, 32'hFFFFFFFB);
      ld(32'd12, 3'b101, 32'h0000FFFB);
      drain();

      // Byte-lane merges.
      st(32'd8, 32'h11223344, 3'b010);
      st(32'd9, 32'h000000AA, 3'b000);
      st(32'd10, 32'h0000BEEF, 3'b001);
      ld(32'd8, 3'b010, 32'hBEEFAA44);
      ld(32'd9, 3'b000, 32'hFFFFFFAA);
      ld(32'd10, 3'b101, 32'h0000BEEF);
      ld(32'd11, 3'b100, 32'h000000BE);
      drain();

      // Unused funct3 encodings act as full-word accesses.
      st(32'd24, 32'hA5A5A5A5, 3'b011);
      ld(32'd24, 3'b110, 32'hA5A5A5A5);
      st(32'd28, 32'h0F0F1234, 3'b111);
      ld(32'd28, 3'b011, 32'h0F0F1234);
      drain();

      // Address wrap modulo the array size.
      st(32'(4 * DEPTH + 16), 32'h600DCAFE, 3'b010);
      ld(32'd16, 3'b010, 32'h600DCAFE);
      drain();

      // Misaligned store/load behaviour.
      st(32'd0, 32'h12345678, 3'b010);
      st(32'd2, 32'h00000005, 3'b010);
      ld(32'd0, 3'b010, TRAP ? 32'h12345678 : 32'h00000005);
      ld(32'd2, 3'b010, TRAP ? 32'h0 : 32'h00000005);
      ld(32'd1, 3'b001, TRAP ? 32'h0 : 32'h00000005);
      drain();

      // Back-pressure: response held for several cycles.
      st(32'd20, 32'hCAFEF00D, 3'b010);
      i_dm_rsp_ready = 1'b0;
      ld(32'd20, 3'b010, 32'hCAFEF00D);
      guard = 0;
      while (!o_dm_rsp_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq("stall_rsp_seen", 32'(o_dm_rsp_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check_eq("stall_valid_held", 32'(o_dm_rsp_valid), 32'd1);
         check_eq("stall_data_held", o_dm_data_out, 32'hCAFEF00D);
         check_eq("stall_req_ready_low", 32'(o_dm_req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      i_dm_rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("idle_after_handshake", 32'(o_dm_req_ready), 32'd1);
      check_eq("valid_low_after_hs", 32'(o_dm_rsp_valid), 32'd0);
      drain();

      // Reset while a load is in flight.
      issue(1'b0, 32'd20, 32'h0, 3'b010, 1'b0, 32'h0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_valid_low", 32'(o_dm_rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 3) begin
         @(negedge clk);
         check_eq("no_rsp_after_rst", 32'(o_dm_rsp_valid), 32'd0);
         check_eq("ready_after_rst", 32'(o_dm_req_ready), 32'd1);
      end
      st(32'd4, 32'h0BADF00D, 3'b010);
      ld(32'd4, 3'b010, 32'h0BADF00D);
      drain();

      // Randomised run over words 32..47 against the reference model.
      for (int i = 0; i < 16; i++) st(32'h80 + 32'(4 * i), $urandom, 3'b010);
      for (int i = 0; i < 60; i++) begin
         a  = 32'h80 + 32'($urandom_range(0, 63));
         d  = $urandom;
         f3 = 3'($urandom_range(0, 7));
         we = 1'($urandom_range(0, 1));
         if (we) st(a, d, f3);
         else    ld(a, f3, model_load(a, f3));
      end
      drain();

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32im_dmem_pipe.md
RV32IM_DMEM_PIPE -- requirements
Module: rv32im_dmem_pipe

Interface
REQ-001 SHALL provide parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words; power of two, >= 4.
REQ-002 SHALL provide parameter READ_LAT, default 2, meaning cycles from load acceptance to response valid; legal range 1..4.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-004 SHALL provide port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL provide port rst_n, input, 1, meaning reset; asynchronous assert, active-low.
REQ-006 SHALL provide port i_dm_req_valid, input, 1, meaning request present.
REQ-007 SHALL provide port o_dm_req_ready, output, 1, meaning request can be accepted.
REQ-008 SHALL provide port i_dm_we, input, 1, meaning 1 = store, 0 = load.
REQ-009 SHALL provide port i_dm_addr, input, ADDR_WIDTH, meaning byte address.
REQ-010 SHALL provide port i_dm_data_in, input, 32, meaning store data, right-aligned.
REQ-011 SHALL provide port i_dm_func3, input, 3, meaning RV32 funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
REQ-012 SHALL provide port o_dm_rsp_valid, output, 1, meaning load response present.
REQ-013 SHALL provide port i_dm_rsp_ready, input, 1, meaning consumer takes the response.
REQ-014 SHALL provide port o_dm_data_out, output, 32, meaning extended load data.
REQ-015 SHALL provide port o_dm_misalign, output, 1, meaning one-cycle pulse on a misaligned accepted request.

Function
REQ-016 SHALL accept a request on a rising edge only when i_dm_req_valid and o_dm_req_ready are both 1.
REQ-017 SHALL implement the FSM IDLE -> LWAIT on load accept -> RESP when the latency counter expires -> IDLE when o_dm_rsp_valid and i_dm_rsp_ready are both 1; store accept stays in IDLE.
REQ-018 SHALL drive o_dm_req_ready = 1 only in IDLE, so at most one load is outstanding.
REQ-019 SHALL write a store in the accept edge using byte lanes: SB lane addr[1:0], SH lanes {addr[1],0}+0/1, SW all four lanes; lanes not written are unchanged.
REQ-020 SHALL index words with addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-021 SHALL assert o_dm_rsp_valid exactly READ_LAT cycles after load acceptance and hold o_dm_rsp_valid and o_dm_data_out stable until handshake.
REQ-022 SHALL sign-extend LB/LH results, zero-extend LBU/LHU results, and pass LW results unmodified, selecting bytes by addr[1:0].
REQ-023 SHALL sample load data at acceptance-time memory contents, so a store accepted the cycle before a load to the same word is visible.
REQ-024 SHALL treat unused funct3 encodings: as a full-word store when a store, and as an LW when a load.
REQ-025 SHALL hold o_dm_data_out at 0 whenever o_dm_rsp_valid is 0.

Reset
REQ-026 SHALL, when rst_n is low, force the FSM to IDLE, clear the latency counter, drive o_dm_rsp_valid=0, o_dm_data_out=0, o_dm_misalign=0 and o_dm_req_ready=1 after release.
REQ-027 SHALL discard an in-flight load on reset and leave memory contents unspecified (not cleared).

Configuration
REQ-028 SHALL, with DMEM_MISALIGN_TRAP_EN defined, pulse o_dm_misalign for a halfword with addr[0]=1 or a word with addr[1:0]!=0, suppress a misaligned store, and return data 0 with a normal response for a misaligned load.
REQ-029 SHALL, without DMEM_MISALIGN_TRAP_EN, tie o_dm_misalign to 0 and force the offending low address bits to 0 (access aligned down).

Verification
REQ-030 SHALL verify SW 0xDEADBEEF @0, then LW @0 -> rsp_valid exactly READ_LAT cycles after accept, data 0xDEADBEEF.
REQ-031 SHALL verify SW 0xFFFFFFFB @12, then LB/LBU/LH/LHU @12 -> 0xFFFFFFFB, 0x000000FB, 0xFFFFFFFB, 0x0000FFFB respectively.
REQ-032 SHALL verify SW 0x11223344 @8, SB 0xAA @9, SH 0xBEEF @10, then LW @8 -> 0xBEEFAA44.
REQ-033 SHALL verify a load with i_dm_rsp_ready held 0 for 5 cycles -> rsp_valid and data held, req_ready 0 throughout, returning to IDLE one cycle after ready.
REQ-034 SHALL verify, with the macro defined, SW 0x5 @2 -> o_dm_misalign pulse and word @0 unchanged; without the macro, the same stimulus writes word @0.
REQ-035 SHALL verify rst_n pulsed low during LWAIT -> no response emitted, req_ready=1 after release, and a subsequent SW @4 then LW @4 returns the stored value.
